// File: rtl/reg_file_pkg.sv
// Shared processor package: datapath width defaults and architectural register constants.
// Imported by the register file, datapath muxes and ALU.
package reg_file_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_REG       = 0;

    // True when a write to the given index may update architectural state.
    function automatic logic is_writable_index(input int unsigned idx);
        return idx != ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_file_word.sv
// reg_word: one WIDTH-bit architectural register with write enable and synchronous reset.
// Reset wins over a same-edge write.
module reg_word
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x WIDTH register file, one write port, two combinational read ports.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH      = DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rg_wrt_en,
    input  logic [ADDR_WIDTH-1:0] rg_wrt_addr,
    input  logic [WIDTH-1:0]      rg_wrt_data,
    input  logic [ADDR_WIDTH-1:0] rg_rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rg_rd_addr2,
    output logic [WIDTH-1:0]      rg_rd_data1,
    output logic [WIDTH-1:0]      rg_rd_data2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] regs [NUM_REGS];

    // Index 0 is hard-wired zero; every other index is a reg_word.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        if (!is_writable_index(i)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_word
            logic wr_sel;
            assign wr_sel = rg_wrt_en && (rg_wrt_addr == ADDR_WIDTH'(i));
            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk   (clk),
                .reset (reset),
                .en    (wr_sel),
                .d     (rg_wrt_data),
                .q     (regs[i])
            );
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = rg_wrt_en && !reset && (rg_wrt_addr != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        rg_rd_data1 = regs[rg_rd_addr1];
        rg_rd_data2 = regs[rg_rd_addr2];
        if (fwd_ok && (rg_wrt_addr == rg_rd_addr1)) begin
            rg_rd_data1 = rg_wrt_data;
        end
        if (fwd_ok && (rg_wrt_addr == rg_rd_addr2)) begin
            rg_rd_data2 = rg_wrt_data;
        end
    end
`else
    // Reads see the stored value; a same-cycle write becomes visible next cycle.
    always_comb begin
        rg_rd_data1 = regs[rg_rd_addr1];
        rg_rd_data2 = regs[rg_rd_addr2];
    end
`endif

endmodule
